cpu_control_unit: RTL and testbench

- Hardwired Moore control sequencer for the 32-bit bus-based CPU.
- Sits directly upstream of the datapath. Consumes the datapath's IR contents and CON flag.
- Drives every datapath strobe: bus-source selects, register enables, memory read/write, ALU op, and the select/encode controls.
- Executes one instruction as fetch T0–T2 followed by execute steps T3–T7.

---
 rtl/cpu_control_unit_if.sv | 41 ++++
 rtl/cpu_control_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_unit_if.sv
// Strobe and status bundle between the control unit and the datapath.
// CU_SINGLE_STEP_EN adds the step input used by the single-step PAUSE state.
interface cpu_control_unit_if;
  logic [31:0] ir;
  logic con;
  logic stop;
`ifdef CU_SINGLE_STEP_EN
  logic step;
`endif
  logic [7:0] bus_out;
  logic [11:0] reg_en;
  logic [5:0] gr_ctl;
  logic read;
  logic write;
  logic [11:0] alu_op;
  logic run;

`ifdef CU_SINGLE_STEP_EN
  modport master (
    input ir, con, stop, step,
    output bus_out, reg_en, gr_ctl,
    output read, write, alu_op, run
  );
  modport slave (
    output ir, con, stop, step,
    input bus_out, reg_en, gr_ctl,
    input read, write, alu_op, run
  );
`else
  modport master (
    input ir, con, stop,
    output bus_out, reg_en, gr_ctl,
    output read, write, alu_op, run
  );
  modport slave (
    output ir, con, stop,
    input bus_out, reg_en, gr_ctl,
    input read, write, alu_op, run
  );
`endif
endinterface

// File: rtl/cpu_control_unit.sv
// Hardwired Moore sequencer: fetch T0-T2, execute T3-T7, memory steps held MEM_WAIT cycles.
// Optional CU_SINGLE_STEP_EN: PAUSE after each instruction until a step rising edge.
module cpu_control_unit #(
  parameter int MEM_WAIT = 1
) (
  input logic clk,
  input logic clr,
  cpu_control_unit_if.master cu
);
  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef CU_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  localparam int B_C = 7;
  localparam int B_IN = 6;
  localparam int B_MDR = 5;
  localparam int B_PC = 4;
  localparam int B_ZLO = 3;
  localparam int B_ZHI = 2;
  localparam int B_LO = 1;
  localparam int B_HI = 0;

  localparam int E_MAR = 11;
  localparam int E_PC = 10;
  localparam int E_MDR = 9;
  localparam int E_IR = 8;
  localparam int E_Y = 7;
  localparam int E_INC = 6;
  localparam int E_HI = 5;
  localparam int E_LO = 4;
  localparam int E_OUT = 2;
  localparam int E_Z = 1;
  localparam int E_CON = 0;

  localparam int G_A = 5;
  localparam int G_B = 4;
  localparam int G_C = 3;
  localparam int G_RIN = 2;
  localparam int G_ROUT = 1;
  localparam int G_BA = 0;

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  state_t state, nxt;
  logic [2:0] cnt, cnt_d;
  logic mem_st, wait_done;

  logic [4:0] op;
  logic unused_ir;
  assign op = cu.ir[31:27];
  assign unused_ir = ^cu.ir[26:0];

  logic c_ld, c_ldi, c_st, c_addr;
  logic c_rop, c_imm, c_alu, c_md, c_nn;
  logic c_br, c_jr, c_in, c_out;
  logic c_hi, c_lo, c_halt;

  assign c_ld = op == 5'd0;
  assign c_ldi = op == 5'd1;
  assign c_st = op == 5'd2;
  assign c_addr = c_ld | c_ldi | c_st;
  assign c_rop = op >= 5'd3 && op <= 5'd10;
  assign c_imm = op >= 5'd11 && op <= 5'd13;
  assign c_alu = c_rop | c_imm;
  assign c_md = op == 5'd14 || op == 5'd15;
  assign c_nn = op == 5'd16 || op == 5'd17;
  assign c_br = op == 5'd18;
  assign c_jr = op == 5'd19;
  assign c_in = op == 5'd20;
  assign c_out = op == 5'd21;
  assign c_hi = op == 5'd22;
  assign c_lo = op == 5'd23;
  assign c_halt = op == 5'd25;

  function automatic logic [11:0] alu_sel(
    input logic [4:0] o
  );
    logic [11:0] a;
    a = '0;
    case (o)
      5'd3, 5'd11: a[0] = 1'b1;
      5'd4: a[1] = 1'b1;
      5'd14: a[2] = 1'b1;
      5'd15: a[3] = 1'b1;
      5'd9, 5'd12: a[4] = 1'b1;
      5'd10, 5'd13: a[5] = 1'b1;
      5'd5: a[6] = 1'b1;
      5'd6: a[7] = 1'b1;
      5'd7: a[8] = 1'b1;
      5'd8: a[9] = 1'b1;
      5'd16: a[10] = 1'b1;
      5'd17: a[11] = 1'b1;
      default: a = '0;
    endcase
    return a;
  endfunction

  logic [11:0] op_alu;
  assign op_alu = alu_sel(op);

  assign mem_st = state == S_T1
    || (state == S_T6 && c_ld)
    || (state == S_T7 && c_st);
  assign wait_done = cnt == LAST;
  // counter only advances while a memory step is still holding
  assign cnt_d = (mem_st && !wait_done) ?
    cnt + 3'd1 : 3'd0;

`ifdef CU_SINGLE_STEP_EN
  logic step_q, step_rise;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) step_q <= 1'b0;
    else step_q <= cu.step;
  end
  assign step_rise = cu.step & ~step_q;
  localparam state_t S_FIN = S_PAUSE;
`else
  localparam state_t S_FIN = S_T0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_RESET;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_d;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_RESET: nxt = S_T0;
      S_T0: nxt = cu.stop ? S_HALT : S_T1;
      S_T1: nxt = wait_done ? S_T2 : S_T1;
      S_T2: nxt = S_T3;
      S_T3: begin
        unique case (1'b1)
          c_halt: nxt = S_HALT;
          c_addr, c_alu, c_md, c_nn, c_br:
            nxt = S_T4;
          default: nxt = S_FIN;
        endcase
      end
      S_T4: nxt = c_nn ? S_FIN : S_T5;
      S_T5: nxt = (c_ld | c_st | c_md | c_br) ?
        S_T6 : S_FIN;
      S_T6: begin
        if (c_ld) nxt = wait_done ? S_T7 : S_T6;
        else if (c_st) nxt = S_T7;
        else nxt = S_FIN;
      end
      S_T7: nxt = (c_st && !wait_done) ?
        S_T7 : S_FIN;
      S_HALT: nxt = S_HALT;
`ifdef CU_SINGLE_STEP_EN
      S_PAUSE: nxt = step_rise ? S_T0 : S_PAUSE;
`endif
      default: nxt = S_RESET;
    endcase
  end

  logic [7:0] bus;
  logic [11:0] en;
  logic [5:0] gr;
  logic [11:0] alu;
  logic rd, wr, run;

  always_comb begin
    bus = '0;
    en = '0;
    gr = '0;
    alu = '0;
    rd = 1'b0;
    wr = 1'b0;
    run = state != S_RESET && state != S_HALT;
    unique case (state)
      S_T0: begin
        bus[B_PC] = 1'b1;
        en[E_MAR] = 1'b1;
        en[E_INC] = 1'b1;
        en[E_Z] = 1'b1;
      end
      S_T1: begin
        bus[B_ZLO] = 1'b1;
        rd = 1'b1;
        en[E_MDR] = 1'b1;
        en[E_PC] = wait_done;
      end
      S_T2: begin
        bus[B_MDR] = 1'b1;
        en[E_IR] = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          c_addr: begin
            gr[G_B] = 1'b1;
            gr[G_BA] = 1'b1;
            en[E_Y] = 1'b1;
          end
          c_alu: begin
            gr[G_B] = 1'b1;
            gr[G_ROUT] = 1'b1;
            en[E_Y] = 1'b1;
          end
          c_md: begin
            gr[G_A] = 1'b1;
            gr[G_ROUT] = 1'b1;
            en[E_Y] = 1'b1;
          end
          c_nn: begin
            gr[G_B] = 1'b1;
            gr[G_ROUT] = 1'b1;
            alu = op_alu;
            en[E_Z] = 1'b1;
          end
          c_br: begin
            gr[G_A] = 1'b1;
            gr[G_ROUT] = 1'b1;
            en[E_CON] = 1'b1;
          end
          c_jr: begin
            gr[G_A] = 1'b1;
            gr[G_ROUT] = 1'b1;
            en[E_PC] = 1'b1;
          end
          c_in: begin
            bus[B_IN] = 1'b1;
            gr[G_A] = 1'b1;
            gr[G_RIN] = 1'b1;
          end
          c_out: begin
            gr[G_A] = 1'b1;
            gr[G_ROUT] = 1'b1;
            en[E_OUT] = 1'b1;
          end
          c_hi: begin
            bus[B_HI] = 1'b1;
            gr[G_A] = 1'b1;
            gr[G_RIN] = 1'b1;
          end
          c_lo: begin
            bus[B_LO] = 1'b1;
            gr[G_A] = 1'b1;
            gr[G_RIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          c_addr, c_imm: begin
            bus[B_C] = 1'b1;
            alu = c_addr ? 12'h001 : op_alu;
            en[E_Z] = 1'b1;
          end
          c_rop: begin
            gr[G_C] = 1'b1;
            gr[G_ROUT] = 1'b1;
            alu = op_alu;
            en[E_Z] = 1'b1;
          end
          c_md: begin
            gr[G_B] = 1'b1;
            gr[G_ROUT] = 1'b1;
            alu = op_alu;
            en[E_Z] = 1'b1;
          end
          c_nn: begin
            bus[B_ZLO] = 1'b1;
            gr[G_A] = 1'b1;
            gr[G_RIN] = 1'b1;
          end
          c_br: begin
            bus[B_PC] = 1'b1;
            en[E_Y] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          c_ld, c_st: begin
            bus[B_ZLO] = 1'b1;
            en[E_MAR] = 1'b1;
          end
          c_ldi, c_alu: begin
            bus[B_ZLO] = 1'b1;
            gr[G_A] = 1'b1;
            gr[G_RIN] = 1'b1;
          end
          c_md: begin
            bus[B_ZLO] = 1'b1;
            en[E_LO] = 1'b1;
          end
          c_br: begin
            bus[B_C] = 1'b1;
            alu[0] = 1'b1;
            en[E_Z] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          c_ld: begin
            rd = 1'b1;
            en[E_MDR] = 1'b1;
          end
          c_st: begin
            gr[G_A] = 1'b1;
            gr[G_ROUT] = 1'b1;
            en[E_MDR] = 1'b1;
          end
          c_md: begin
            bus[B_ZHI] = 1'b1;
            en[E_HI] = 1'b1;
          end
          c_br: begin
            bus[B_ZLO] = 1'b1;
            en[E_PC] = cu.con;
          end
          default: ;
        endcase
      end
      S_T7: begin
        if (c_ld) begin
          bus[B_MDR] = 1'b1;
          gr[G_A] = 1'b1;
          gr[G_RIN] = 1'b1;
        end else if (c_st) begin
          wr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cu.bus_out = bus;
  assign cu.reg_en = en;
  assign cu.gr_ctl = gr;
  assign cu.read = rd;
  assign cu.write = wr;
  assign cu.alu_op = alu;
  assign cu.run = run;
endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed table, corner sequences,
// and random instruction streams against a per-instruction step-list model.
module tb_cpu_control_unit;
  typedef struct packed {
    logic [7:0] bus;
    logic [11:0] en;
    logic [5:0] gr;
    logic rd;
    logic wr;
    logic [11:0] alu;
    logic run;
  } outv_t;

  typedef struct {
    logic [31:0] ir;
    logic con;
    int mw;
    int len;
    int k;
    outv_t exp;
    string name;
  } vec_t;

  localparam logic [7:0] COUT = 8'h80;
  localparam logic [7:0] INP = 8'h40;
  localparam logic [7:0] MDRO = 8'h20;
  localparam logic [7:0] PCO = 8'h10;
  localparam logic [7:0] ZLO = 8'h08;
  localparam logic [7:0] ZHI = 8'h04;
  localparam logic [7:0] LOO = 8'h02;
  localparam logic [7:0] HIO = 8'h01;

  localparam logic [11:0] MARI = 12'h800;
  localparam logic [11:0] PCI = 12'h400;
  localparam logic [11:0] MDRI = 12'h200;
  localparam logic [11:0] IRI = 12'h100;
  localparam logic [11:0] YI = 12'h080;
  localparam logic [11:0] INC = 12'h040;
  localparam logic [11:0] HII = 12'h020;
  localparam logic [11:0] LOI = 12'h010;
  localparam logic [11:0] OUTI = 12'h004;
  localparam logic [11:0] ZI = 12'h002;
  localparam logic [11:0] CONI = 12'h001;

  localparam logic [5:0] GA = 6'h20;
  localparam logic [5:0] GB = 6'h10;
  localparam logic [5:0] GC = 6'h08;
  localparam logic [5:0] RIN = 6'h04;
  localparam logic [5:0] ROUT = 6'h02;
  localparam logic [5:0] BA = 6'h01;

  localparam logic [11:0] ADD = 12'h001;
  localparam outv_t OFF = '0;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int checks = 0;
  int errors = 0;
  outv_t exp_q[$];
  outv_t got_q[$];
  vec_t tbl[$];

  cpu_control_unit_if ifa();
  cpu_control_unit_if ifb();

  cpu_control_unit #(.MEM_WAIT(1)) dut_a (
    .clk(clk), .clr(clr), .cu(ifa)
  );
  cpu_control_unit #(.MEM_WAIT(3)) dut_b (
    .clk(clk), .clr(clr), .cu(ifb)
  );

  always #5 clk = ~clk;

  function automatic outv_t mk(
    input logic [7:0] b, input logic [11:0] e,
    input logic [5:0] g, input logic rd,
    input logic wr, input logic [11:0] a
  );
    outv_t v;
    v.bus = b;
    v.en = e;
    v.gr = g;
    v.rd = rd;
    v.wr = wr;
    v.alu = a;
    v.run = 1'b1;
    return v;
  endfunction

  function automatic logic [11:0] alu_of(input logic [4:0] op);
    int idx;
    case (op)
      5'd3, 5'd11: idx = 0;
      5'd4: idx = 1;
      5'd14: idx = 2;
      5'd15: idx = 3;
      5'd9, 5'd12: idx = 4;
      5'd10, 5'd13: idx = 5;
      5'd5: idx = 6;
      5'd6: idx = 7;
      5'd7: idx = 8;
      5'd8: idx = 9;
      5'd16: idx = 10;
      5'd17: idx = 11;
      default: idx = -1;
    endcase
    return (idx < 0) ? 12'h0 : (12'h001 << idx);
  endfunction

  // Expected output of every cycle of one instruction, starting at T0.
  function automatic void model(
    input logic [4:0] op, input logic con, input int mw
  );
    logic [11:0] a;
    a = alu_of(op);
    exp_q.delete();
    exp_q.push_back(mk(PCO, MARI | INC | ZI, '0, 1'b0, 1'b0, '0));
    for (int i = 0; i < mw; i++)
      exp_q.push_back(mk(ZLO, MDRI | ((i == mw - 1) ? PCI : 12'h0),
        '0, 1'b1, 1'b0, '0));
    exp_q.push_back(mk(MDRO, IRI, '0, 1'b0, 1'b0, '0));
    case (op) inside
      [5'd0:5'd2]: begin
        exp_q.push_back(mk('0, YI, GB | BA, 1'b0, 1'b0, '0));
        exp_q.push_back(mk(COUT, ZI, '0, 1'b0, 1'b0, ADD));
        if (op == 5'd1) begin
          exp_q.push_back(mk(ZLO, '0, GA | RIN, 1'b0, 1'b0, '0));
        end else begin
          exp_q.push_back(mk(ZLO, MARI, '0, 1'b0, 1'b0, '0));
          if (op == 5'd0) begin
            for (int i = 0; i < mw; i++)
              exp_q.push_back(mk('0, MDRI, '0, 1'b1, 1'b0, '0));
            exp_q.push_back(mk(MDRO, '0, GA | RIN, 1'b0, 1'b0, '0));
          end else begin
            exp_q.push_back(mk('0, MDRI, GA | ROUT, 1'b0, 1'b0, '0));
            for (int i = 0; i < mw; i++)
              exp_q.push_back(mk('0, '0, '0, 1'b0, 1'b1, '0));
          end
        end
      end
      [5'd3:5'd13]: begin
        exp_q.push_back(mk('0, YI, GB | ROUT, 1'b0, 1'b0, '0));
        if (op >= 5'd11)
          exp_q.push_back(mk(COUT, ZI, '0, 1'b0, 1'b0, a));
        else
          exp_q.push_back(mk('0, ZI, GC | ROUT, 1'b0, 1'b0, a));
        exp_q.push_back(mk(ZLO, '0, GA | RIN, 1'b0, 1'b0, '0));
      end
      5'd14, 5'd15: begin
        exp_q.push_back(mk('0, YI, GA | ROUT, 1'b0, 1'b0, '0));
        exp_q.push_back(mk('0, ZI, GB | ROUT, 1'b0, 1'b0, a));
        exp_q.push_back(mk(ZLO, LOI, '0, 1'b0, 1'b0, '0));
        exp_q.push_back(mk(ZHI, HII, '0, 1'b0, 1'b0, '0));
      end
      5'd16, 5'd17: begin
        exp_q.push_back(mk('0, ZI, GB | ROUT, 1'b0, 1'b0, a));
        exp_q.push_back(mk(ZLO, '0, GA | RIN, 1'b0, 1'b0, '0));
      end
      5'd18: begin
        exp_q.push_back(mk('0, CONI, GA | ROUT, 1'b0, 1'b0, '0));
        exp_q.push_back(mk(PCO, YI, '0, 1'b0, 1'b0, '0));
        exp_q.push_back(mk(COUT, ZI, '0, 1'b0, 1'b0, ADD));
        exp_q.push_back(mk(ZLO, con ? PCI : 12'h0, '0, 1'b0, 1'b0, '0));
      end
      5'd19: exp_q.push_back(mk('0, PCI, GA | ROUT, 1'b0, 1'b0, '0));
      5'd20: exp_q.push_back(mk(INP, '0, GA | RIN, 1'b0, 1'b0, '0));
      5'd21: exp_q.push_back(mk('0, OUTI, GA | ROUT, 1'b0, 1'b0, '0));
      5'd22: exp_q.push_back(mk(HIO, '0, GA | RIN, 1'b0, 1'b0, '0));
      5'd23: exp_q.push_back(mk(LOO, '0, GA | RIN, 1'b0, 1'b0, '0));
      default: exp_q.push_back(mk('0, '0, '0, 1'b0, 1'b0, '0));
    endcase
  endfunction

  function automatic outv_t get_out(input int mw);
    outv_t v;
    if (mw == 1)
      v = {ifa.bus_out, ifa.reg_en, ifa.gr_ctl, ifa.read,
           ifa.write, ifa.alu_op, ifa.run};
    else
      v = {ifb.bus_out, ifb.reg_en, ifb.gr_ctl, ifb.read,
           ifb.write, ifb.alu_op, ifb.run};
    return v;
  endfunction

  task automatic drive(input logic [31:0] ir, input logic con,
                       input logic stop);
    ifa.ir = ir;
    ifa.con = con;
    ifa.stop = stop;
    ifb.ir = ir;
    ifb.con = con;
    ifb.stop = stop;
  endtask

  task automatic chk(input string name, input outv_t g, input outv_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got bus=%h en=%h gr=%h rd=%b wr=%b alu=%h run=%b required bus=%h en=%h gr=%h rd=%b wr=%b alu=%h run=%b",
        name, g.bus, g.en, g.gr, g.rd, g.wr, g.alu, g.run,
        e.bus, e.en, e.gr, e.rd, e.wr, e.alu, e.run);
    end
  endtask

  task automatic chk_inv(input string name, input outv_t g);
    checks++;
    if ($countones(g.bus) > 1 || $countones(g.alu) > 1 || (g.rd && g.wr)) begin
      errors++;
      $display("FAIL %s exclusivity: got bus=%h alu=%h rd=%b wr=%b required one-hot bus/alu and not rd&wr",
        name, g.bus, g.alu, g.rd, g.wr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic collect(input int mw, input logic [31:0] ir,
                         input logic con, input int n, input string name);
    drive(ir, con, 1'b0);
    got_q.delete();
    for (int k = 0; k < n; k++) begin
      outv_t g;
      g = get_out(mw);
      got_q.push_back(g);
      chk_inv(name, g);
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input int mw, input logic [31:0] ir,
                           input logic con, input string name);
    model(ir[31:27], con, mw);
    collect(mw, ir, con, exp_q.size(), name);
    for (int k = 0; k < exp_q.size(); k++)
      chk($sformatf("%s step %0d", name, k), got_q[k], exp_q[k]);
  endtask

  function automatic void add_vec(
    input logic [4:0] op, input logic con, input int mw,
    input int len, input int k, input outv_t e, input string name
  );
    vec_t v;
    v.ir = (op == 5'd3) ? 32'h18918000 : {op, 27'h0918000};
    v.con = con;
    v.mw = mw;
    v.len = len;
    v.k = k;
    v.exp = e;
    v.name = name;
    tbl.push_back(v);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    outv_t t0v;
    t0v = mk(PCO, MARI | INC | ZI, '0, 1'b0, 1'b0, '0);
    drive('0, 1'b0, 1'b0);
`ifdef CU_SINGLE_STEP_EN
    ifa.step = 1'b0;
    ifb.step = 1'b0;
`endif

    add_vec(5'd3, 0, 1, 6, 4, mk('0, ZI, 6'b001010, 0, 0, 12'h001), "add T4");
    add_vec(5'd3, 0, 1, 6, 5, mk(ZLO, '0, 6'h24, 0, 0, '0), "add T5");
    add_vec(5'd0, 0, 3, 12, 1, mk(ZLO, 12'h200, '0, 1, 0, '0), "ld T1 first");
    add_vec(5'd0, 0, 3, 12, 3, mk(ZLO, 12'h600, '0, 1, 0, '0), "ld T1 last");
    add_vec(5'd0, 0, 3, 12, 10, mk('0, 12'h200, '0, 1, 0, '0), "ld T6 last");
    add_vec(5'd0, 0, 3, 12, 11, mk(8'h20, '0, 6'h24, 0, 0, '0), "ld T7");
    add_vec(5'd2, 0, 3, 12, 8, mk('0, 12'h200, 6'h22, 0, 0, '0), "st T6");
    add_vec(5'd2, 0, 3, 12, 9, mk('0, '0, '0, 0, 1, '0), "st T7 first");
    add_vec(5'd2, 0, 3, 12, 11, mk('0, '0, '0, 0, 1, '0), "st T7 last");
    add_vec(5'd1, 0, 3, 8, 5, mk('0, 12'h080, 6'h11, 0, 0, '0), "ldi T3");
    add_vec(5'd18, 1, 1, 7, 6, mk(ZLO, 12'h400, '0, 0, 0, '0), "br con1 T6");
    add_vec(5'd18, 0, 1, 7, 6, mk(ZLO, 12'h000, '0, 0, 0, '0), "br con0 T6");
    add_vec(5'd14, 0, 1, 7, 4, mk('0, 12'h002, 6'h12, 0, 0, 12'h004), "mul T4");
    add_vec(5'd15, 0, 1, 7, 6, mk(8'h04, 12'h020, '0, 0, 0, '0), "div T6");
    add_vec(5'd16, 0, 1, 5, 3, mk('0, 12'h002, 6'h12, 0, 0, 12'h400), "neg T3");
    add_vec(5'd19, 0, 1, 4, 3, mk('0, 12'h400, 6'h22, 0, 0, '0), "jr T3");
    add_vec(5'd20, 0, 1, 4, 3, mk(8'h40, '0, 6'h24, 0, 0, '0), "in T3");
    add_vec(5'd21, 0, 1, 4, 3, mk('0, 12'h004, 6'h22, 0, 0, '0), "out T3");
    add_vec(5'd22, 0, 1, 4, 3, mk(8'h01, '0, 6'h24, 0, 0, '0), "mfhi T3");
    add_vec(5'd13, 0, 1, 6, 4, mk(8'h80, 12'h002, '0, 0, 0, 12'h020), "ori T4");
    add_vec(5'd24, 0, 1, 4, 3, mk('0, '0, '0, 0, 0, '0), "nop T3");
    add_vec(5'd31, 0, 3, 6, 5, mk('0, '0, '0, 0, 0, '0), "undef T3");

    #1;
    chk("reset state a", get_out(1), OFF);
    chk("reset state b", get_out(3), OFF);

    foreach (tbl[i]) begin
      do_reset();
      collect(tbl[i].mw, tbl[i].ir, tbl[i].con, tbl[i].len, tbl[i].name);
      chk(tbl[i].name, got_q[tbl[i].k], tbl[i].exp);
      chk({tbl[i].name, " next T0"}, get_out(tbl[i].mw), t0v);
    end

    // clr in the middle of a ld with MEM_WAIT=3
    do_reset();
    drive({5'd0, 27'h0918000}, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr async b", get_out(3), OFF);
    chk("clr async a", get_out(1), OFF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("clr hold %0d", c), get_out(3), OFF);
    end
    clr = 1'b0;
    @(negedge clk);
    chk("clr release T0", get_out(3), t0v);
    run_instr(3, {5'd0, 27'h0918000}, 1'b0, "ld after clr");
    run_instr(3, 32'h18918000, 1'b0, "add after ld");

    // halt opcode
    do_reset();
    run_instr(1, {5'd25, 27'h0}, 1'b0, "halt");
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("halted %0d", c), get_out(1), OFF);
      @(negedge clk);
    end

    // stop request in T0
    do_reset();
    drive({5'd3, 27'h0}, 1'b0, 1'b1);
    chk("stop T0", get_out(1), t0v);
    @(negedge clk);
    drive({5'd3, 27'h0}, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stop halted %0d", c), get_out(1), OFF);
      @(negedge clk);
    end

    // random back-to-back streams for both wait settings
    for (int w = 0; w < 2; w++) begin
      int mw;
      mw = (w == 0) ? 1 : 3;
      do_reset();
      for (int n = 0; n < 40; n++) begin
        logic [4:0] op;
        logic con;
        op = 5'($urandom_range(0, 31));
        if (op == 5'd25) op = 5'd24;
        con = 1'($urandom_range(0, 1));
        run_instr(mw, {op, 27'($urandom)}, con,
          $sformatf("rnd mw%0d op%0d", mw, op));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
